// File: rtl/plru_way_ctrl.sv
// 8-way set tag/replacement controller feeding a tree PLRU; hit response 1 cycle after accept, misses wait on refill.
// Backpressure: fill_ready/resp_ready stall in place; PLRU_WAY_CTRL_PERF_EN adds saturating hit/miss counters.
module plru_way_ctrl #(
  parameter int TAG_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [2:0]       resp_way,
  output logic             fill_valid,
  input  logic             fill_ready,
  output logic [2:0]       fill_way,
  output logic [TAG_W-1:0] fill_tag,
  input  logic             fill_done,
  input  logic             inv_all,
  output logic             inv_done,
  output logic             acc_en,
  output logic [2:0]       acc_idx,
  input  logic [2:0]       lru_idx
`ifdef PLRU_WAY_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESP} state_t;

  state_t           state;
  logic [TAG_W-1:0] tags [8];
  logic [7:0]       vld;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       way_q;
  logic             hit_q;

  logic             hit;
  logic [2:0]       hit_way;
  logic [2:0]       free_way;
  logic [2:0]       victim;

  // Descending scans so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 3'd0;
    free_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vld[i] && (tags[i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = 3'(i);
      end
      if (!vld[i]) free_way = 3'(i);
    end
    victim = (&vld) ? lru_idx : free_way;
  end

  assign req_ready  = (state == IDLE) && !inv_all;
  assign inv_done   = (state == IDLE) && inv_all;
  assign fill_valid = (state == FILL_REQ);
  assign fill_way   = fill_valid ? way_q : 3'd0;
  assign fill_tag   = fill_valid ? tag_q : '0;
  assign resp_valid = (state == RESP);
  assign resp_hit   = resp_valid & hit_q;
  assign resp_way   = resp_valid ? way_q : 3'd0;
  assign acc_en     = resp_valid & resp_ready;
  assign acc_idx    = acc_en ? way_q : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vld   <= '0;
      tag_q <= '0;
      way_q <= 3'd0;
      hit_q <= 1'b0;
      for (int i = 0; i < 8; i++) tags[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_all) begin
            vld <= '0;
          end else if (req_valid) begin
            tag_q <= req_tag;
            hit_q <= hit;
            way_q <= hit ? hit_way : victim;
            state <= hit ? RESP : FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (fill_ready) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (fill_done) begin
            tags[way_q] <= tag_q;
            vld[way_q]  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLRU_WAY_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (acc_en) begin
      if (hit_q) begin
        if (!(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (!(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_plru_way_ctrl.sv
// Directed + randomized bench for plru_way_ctrl against an array-based set model with a stubbed lru_idx.
module tb_plru_way_ctrl;
  localparam int TAG_W = 20;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic [2:0]       resp_way;
  logic             fill_valid;
  logic             fill_ready;
  logic [2:0]       fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_done;
  logic             inv_all;
  logic             inv_done;
  logic             acc_en;
  logic [2:0]       acc_idx;
  logic [2:0]       lru_idx;
`ifdef PLRU_WAY_CTRL_PERF_EN
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
`endif

  plru_way_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way), .fill_tag(fill_tag),
    .fill_done(fill_done), .inv_all(inv_all), .inv_done(inv_done),
    .acc_en(acc_en), .acc_idx(acc_idx), .lru_idx(lru_idx)
`ifdef PLRU_WAY_CTRL_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference set: what tag lives in each way and whether it is valid.
  logic [TAG_W-1:0] m_tag [8];
  bit               m_vld [8];
  int               m_hits = 0;
  int               m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = '0;
    end
  endtask

  task automatic model_lookup(input logic [TAG_W-1:0] t, output bit h, output logic [2:0] w);
    int free_i;
    h = 1'b0;
    w = 3'd0;
    free_i = -1;
    for (int i = 0; i < 8; i++) begin
      if (!h && m_vld[i] && m_tag[i] == t) begin
        h = 1'b1;
        w = 3'(i);
      end
      if (free_i < 0 && !m_vld[i]) free_i = i;
    end
    if (!h) w = (free_i >= 0) ? 3'(free_i) : lru_idx;
  endtask

  task automatic chk_perf();
`ifdef PLRU_WAY_CTRL_PERF_EN
    chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
`endif
  endtask

  // One complete lookup; fbp/rbp are stall cycles (<0 = random), inv_fill raises inv_all in FILL_WAIT.
  task automatic run_req(input logic [TAG_W-1:0] t, input int fbp, input int rbp, input bit inv_fill);
    bit         eh;
    logic [2:0] ew;
    int         n;
    bit         done;
    bit         filled;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    model_lookup(t, eh, ew);
    req_valid = 1'b1;
    req_tag   = t;
    tick();
    req_valid = 1'b0;
    req_tag   = TAG_W'($urandom);
    chk("resp_valid_after_accept", 32'(resp_valid), 32'(eh));
    chk("fill_valid_after_accept", 32'(fill_valid), 32'(!eh));
    done   = 1'b0;
    filled = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (fill_valid && !filled) begin
        chk("fill_way", 32'(fill_way), 32'(ew));
        chk("fill_tag", 32'(fill_tag), 32'(t));
        n = (fbp < 0) ? int'($urandom_range(0, 3)) : fbp;
        for (int k = 0; k < n; k++) begin
          tick();
          chk("fill_valid_stall", 32'(fill_valid), 32'd1);
          chk("fill_way_stall", 32'(fill_way), 32'(ew));
          chk("fill_tag_stall", 32'(fill_tag), 32'(t));
          chk("req_ready_stall", 32'(req_ready), 32'd0);
        end
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        filled = 1'b1;
        chk("fill_valid_drop", 32'(fill_valid), 32'd0);
        if (inv_fill) inv_all = 1'b1;
        tick();
        chk("inv_done_in_fill_wait", 32'(inv_done), 32'd0);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
      end else if (resp_valid) begin
        chk("resp_hit", 32'(resp_hit), 32'(eh));
        chk("resp_way", 32'(resp_way), 32'(ew));
        n = (rbp < 0) ? int'($urandom_range(0, 3)) : rbp;
        for (int k = 0; k < n; k++) begin
          #1;
          chk("acc_en_stall", 32'(acc_en), 32'd0);
          tick();
          chk("resp_valid_stall", 32'(resp_valid), 32'd1);
          chk("resp_hit_stall", 32'(resp_hit), 32'(eh));
          chk("resp_way_stall", 32'(resp_way), 32'(ew));
          chk("req_ready_resp", 32'(req_ready), 32'd0);
          chk("inv_done_resp", 32'(inv_done), 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("acc_en_handshake", 32'(acc_en), 32'd1);
        chk("acc_idx_handshake", 32'(acc_idx), 32'(ew));
        tick();
        resp_ready = 1'b0;
        chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
        chk("acc_en_after_hs", 32'(acc_en), 32'd0);
        done = 1'b1;
      end else begin
        chk("acc_en_idle_wait", 32'(acc_en), 32'd0);
        tick();
      end
    end
    if (!done) chk("request_timeout", 32'(done), 32'd1);
    if (eh) begin
      m_hits++;
    end else begin
      m_tag[ew] = t;
      m_vld[ew] = 1'b1;
      m_miss++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_tag    = '0;
    resp_ready = 1'b0;
    fill_ready = 1'b0;
    fill_done  = 1'b0;
    inv_all    = 1'b0;
    lru_idx    = 3'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_fill_valid", 32'(fill_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_acc_en", 32'(acc_en), 32'd0);
    chk("rst_acc_idx", 32'(acc_idx), 32'd0);
    chk("rst_inv_done", 32'(inv_done), 32'd0);
    chk_perf();
    rst_n = 1'b1;
    tick();

    // Cold misses fill ways 0..7 in order.
    for (int i = 0; i < 8; i++) begin
      lru_idx = 3'($urandom);
      run_req(TAG_W'(32'h10 + i), 0, 0, 1'b0);
    end
    run_req(TAG_W'(32'h13), 0, 0, 1'b0);

    // Full set: victim comes from lru_idx.
    lru_idx = 3'd5;
    run_req(TAG_W'(32'h99), 0, 0, 1'b0);
    run_req(TAG_W'(32'h99), 0, 0, 1'b0);
    lru_idx = 3'd2;
    run_req(TAG_W'(32'h15), 0, 0, 1'b0);

    // Backpressure on both handshakes.
    lru_idx = 3'd6;
    run_req(TAG_W'(32'h77), 4, 3, 1'b0);
    run_req(TAG_W'(32'h77), 0, 3, 1'b0);
    chk_perf();

    // Random traffic over a tag pool larger than the set.
    for (int i = 0; i < 30; i++) begin
      lru_idx = 3'($urandom);
      run_req(TAG_W'(32'h20 + $urandom_range(0, 11)), -1, -1, 1'b0);
    end
    chk_perf();

    // inv_all raised during a refill only takes effect once back in IDLE.
    lru_idx = 3'd1;
    run_req(TAG_W'(32'h4242), 1, 1, 1'b1);
    chk("inv_done_first_idle", 32'(inv_done), 32'd1);
    chk("req_ready_inv", 32'(req_ready), 32'd0);
    tick();
    model_clear();
    chk("inv_done_held", 32'(inv_done), 32'd1);
    tick();
    chk("inv_done_held2", 32'(inv_done), 32'd1);
    inv_all = 1'b0;
    #1;
    chk("inv_done_released", 32'(inv_done), 32'd0);
    chk("req_ready_after_inv", 32'(req_ready), 32'd1);
    run_req(TAG_W'(32'h13), 0, 0, 1'b0);
    run_req(TAG_W'(32'h4242), 0, 0, 1'b0);
    chk_perf();

    // Asynchronous reset while a refill request is outstanding.
    req_valid = 1'b1;
    req_tag   = TAG_W'(32'h5555);
    tick();
    req_valid = 1'b0;
    chk("fill_valid_pre_reset", 32'(fill_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_fill_valid", 32'(fill_valid), 32'd0);
    chk("areset_resp_valid", 32'(resp_valid), 32'd0);
    chk("areset_acc_en", 32'(acc_en), 32'd0);
    model_clear();
    m_hits = 0;
    m_miss = 0;
    chk_perf();
    tick();
    rst_n = 1'b1;
    tick();
    chk("req_ready_after_release", 32'(req_ready), 32'd1);
    run_req(TAG_W'(32'h13), 0, 0, 1'b0);
    run_req(TAG_W'(32'h4242), 0, 0, 1'b0);
    run_req(TAG_W'(32'h13), 0, 0, 1'b0);
    chk_perf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/plru_way_ctrl.md
Name: plru_way_ctrl

Overview:
- Tag and replacement controller for one 8-way set-associative cache set.
- Sits directly upstream of the set's 8-way tree pseudo-LRU block:
  - consumes that block's lru_idx for victim choice;
  - drives its acc_en/acc_idx so every completed access marks the used way as most recently used.
- Holds 8 tags plus valid bits, resolves hit/miss per request, runs a refill handshake on miss, and returns the way index.

Parameters:
- TAG_W, 20, tag width in bits.
- CNT_W, 16, width of the performance counters; used only under the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept a lookup
- req_tag  in  TAG_W  tag to look up
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_hit  out  1  1 = hit, 0 = miss (refill completed)
- resp_way  out  3  way holding the tag
- fill_valid  out  1  refill request valid
- fill_ready  in  1  refill engine accepts the request
- fill_way  out  3  way to be refilled
- fill_tag  out  TAG_W  tag being refilled
- fill_done  in  1  single-cycle pulse: refill data written
- inv_all  in  1  invalidate all ways (level)
- inv_done  out  1  single-cycle pulse: invalidation performed
- acc_en  out  1  access pulse to the pseudo-LRU block
- acc_idx  out  3  accessed way to the pseudo-LRU block
- lru_idx  in  3  LRU way from the pseudo-LRU block

Behaviour:
- Reset values:
  - state = IDLE;
  - all valid bits = 0; tags = 0;
  - all outputs 0, except req_ready = 1 (IDLE with inv_all low).
- States are IDLE, FILL_REQ, FILL_WAIT, RESP.
- req_ready = 1 only in IDLE with inv_all = 0. A lookup is accepted on req_valid & req_ready.
- Hit rule: hit when any valid way has a tag equal to req_tag. Duplicate tags are never created; the lowest matching index wins defensively.
- Accept cycle behaviour:
  - req_tag is latched.
  - Hit: latch the hit way and go to RESP with resp_hit = 1. resp_valid rises the next cycle (1-cycle latency).
  - Miss: latch the victim and go to FILL_REQ.
- Victim selection:
  - the lowest-index invalid way;
  - if all 8 ways are valid, lru_idx sampled in the accept cycle.
  - The victim is frozen for the whole miss.
- FILL_REQ:
  - fill_valid = 1, with fill_way/fill_tag stable.
  - On fill_ready, go to FILL_WAIT.
- FILL_WAIT:
  - On fill_done: tag[victim] = latched tag, valid[victim] = 1, go to RESP with resp_hit = 0.
  - fill_done in any other state is ignored.
- RESP:
  - resp_valid = 1; resp_hit and resp_way are held until resp_valid & resp_ready.
  - In the handshake cycle: acc_en = 1 for exactly that cycle, acc_idx = resp_way, state returns to IDLE.
  - acc_en/acc_idx are combinational from the handshake; acc_idx = 0 whenever acc_en = 0.
- Back-to-back requests: the earliest next accept is the cycle after the RESP handshake. No request is accepted in the handshake cycle itself. The PLRU update is therefore visible on lru_idx before the next victim sample.
- inv_all:
  - Acted on only in IDLE: clears all valid bits that cycle, pulses inv_done, and blocks acceptance (inv_all has priority over req_valid).
  - Outside IDLE it has no effect; the sender holds it until inv_done.
  - Held for N IDLE cycles: inv_done pulses each such cycle.
- Reset mid-operation: asynchronous return to reset values in any state. An outstanding refill is abandoned; the refill engine is reset by the same rst_n.

Optional Feature:
- Macro: PLRU_WAY_CTRL_PERF_EN.
- Defined:
  - adds outputs hit_cnt and miss_cnt, CNT_W each, reset to 0;
  - incremented in the RESP handshake cycle according to resp_hit;
  - saturate at all-ones (no wrap);
  - inv_all does not clear them.
- Undefined: the counters and ports are absent; all other behaviour is identical.

Test Plan:
- Cold misses:
  - Stimulus: after reset, 8 requests with tags 0x10..0x17; fill_ready = 1; fill_done 2 cycles after each fill handshake.
  - Required: fill_way = 0..7 in order; each resp_hit = 0 with resp_way = fill_way; acc_en pulses once per response with acc_idx = 0..7.
- Hit:
  - Stimulus: request tag 0x13 after the cold fills.
  - Required: resp_valid 1 cycle after accept; resp_hit = 1, resp_way = 3; no fill_valid; acc_en with acc_idx = 3.
- LRU victim:
  - Stimulus: all ways valid, stub lru_idx = 5; request tag 0x99.
  - Required: fill_way = 5; later lookup of 0x99 hits way 5; lookup of 0x15 misses.
- Backpressure:
  - Stimulus: hold fill_ready = 0 for 4 cycles, then resp_ready = 0 for 3 cycles.
  - Required: fill_way/fill_tag and resp_* are stable throughout; req_ready = 0; acc_en only in the final handshake cycle.
- Invalidate:
  - Stimulus: inv_all during FILL_WAIT, then hold until IDLE.
  - Required: no effect until IDLE; inv_done pulses in the first IDLE cycle; req_ready = 0 that cycle; next request 0x13 misses with fill_way = 0.
- Async reset:
  - Stimulus: rst_n low in FILL_REQ.
  - Required: fill_valid, resp_valid, acc_en = 0 immediately; req_ready = 1 after release; previously valid tags all miss. With PLRU_WAY_CTRL_PERF_EN, counters read 0.
